// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl -- read-path controller for a 4-way, 128-set cache
//
// Address split: tag[31:13], index[12:6], word[5:2], byte[1:0].
// Each set has 4 valid bits and 3 tree-PLRU bits, held here. Tags live in an
// external tag store, and line data in an external data array.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   cpu_req_*                  read request (valid/ready, byte address)
//   cpu_resp_*                 read response (valid/ready, word, fill error)
//   flush                      invalidate every line (only honoured in IDLE)
//   ts_index, ts_tag0..3       tag-store lookup (tags returned combinationally)
//   ts_we, ts_windex, ts_way,
//   ts_new_tag                 tag-store write port
//   da_*                       data-array port (combinational read of
//                              index/way/word, single-word write)
//   m_ar*, m_r*                AXI4 read-address and read-data channels
//
// Handshake rule used on every channel: a transfer happens on a rising clk
// edge where both valid and ready are 1. A valid source holds its payload
// stable until that edge, and it never takes valid back before it.
// ---------------------------------------------------------------------------
module cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    input  logic              cpu_resp_ready,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cpu_resp_err,
    input  logic              flush,
    output logic [6:0]        ts_index,
    input  logic [18:0]       ts_tag0,
    input  logic [18:0]       ts_tag1,
    input  logic [18:0]       ts_tag2,
    input  logic [18:0]       ts_tag3,
    output logic              ts_we,
    output logic [6:0]        ts_windex,
    output logic [1:0]        ts_way,
    output logic [18:0]       ts_new_tag,
    output logic              da_we,
    output logic [6:0]        da_index,
    output logic [1:0]        da_way,
    output logic [3:0]        da_word,
    output logic [DATA_W-1:0] da_wdata,
    input  logic [DATA_W-1:0] da_rdata,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
);

    localparam int TAG_W  = 19;
    localparam int IDX_W  = 7;
    localparam int WORD_W = 4;
    localparam int SETS   = 128;
    localparam int WAYS   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_REFILL,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  word_q;
    logic [1:0]         way_q;     // hit way, or victim way during a fill
    logic [WORD_W-1:0]  beat_q;
    logic               err_q;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [2:0]         plru_q  [SETS];

    logic [TAG_W-1:0]   ts_tags [WAYS];
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [1:0]         hit_way;
    logic [1:0]         victim_way;
    logic               r_fire;
    logic               last_beat;

    // The burst length is fixed, so m_rlast carries no extra information.
    // The byte offset is irrelevant to a word read.
    logic unused_ok;
    assign unused_ok = ^{m_rlast, cpu_req_addr[1:0]};

    assign ts_tags[0] = ts_tag0;
    assign ts_tags[1] = ts_tag1;
    assign ts_tags[2] = ts_tag2;
    assign ts_tags[3] = ts_tag3;

    // Tree PLRU: b0=0 -> victim in ways 0/1, b0=1 -> in ways 2/3.
    // b1 picks within 0/1, and b2 picks within 2/3 (bit value = way LSB).
    // A touch turns the bits away from the accessed way.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
        logic [2:0] n;
        n = p;
        if (!way[1]) begin
            n[0] = 1'b1;
            n[1] = ~way[0];
        end else begin
            n[0] = 1'b0;
            n[2] = ~way[0];
        end
        return n;
    endfunction

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[idx_q][w] && (ts_tags[w] == tag_q);
        end
        hit = |hit_vec;

        // Only one way can hit. The priority chain keeps the result defined.
        if (hit_vec[0])      hit_way = 2'd0;
        else if (hit_vec[1]) hit_way = 2'd1;
        else if (hit_vec[2]) hit_way = 2'd2;
        else                 hit_way = 2'd3;

        // An invalid way is always used before PLRU is consulted.
        if (!valid_q[idx_q][0])      victim_way = 2'd0;
        else if (!valid_q[idx_q][1]) victim_way = 2'd1;
        else if (!valid_q[idx_q][2]) victim_way = 2'd2;
        else if (!valid_q[idx_q][3]) victim_way = 2'd3;
        else if (!plru_q[idx_q][0])  victim_way = {1'b0, plru_q[idx_q][1]};
        else                         victim_way = {1'b1, plru_q[idx_q][2]};
    end

    assign r_fire    = (state_q == S_REFILL) && m_rvalid;
    assign last_beat = r_fire && (beat_q == WORD_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            way_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                    end else if (cpu_req_valid) begin
                        tag_q   <= cpu_req_addr[ADDR_W-1:ADDR_W-TAG_W];
                        idx_q   <= cpu_req_addr[12:6];
                        word_q  <= cpu_req_addr[5:2];
                        err_q   <= 1'b0;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        way_q         <= hit_way;
                        plru_q[idx_q] <= plru_touch(plru_q[idx_q], hit_way);
                        state_q       <= S_RESP;
                    end else begin
                        way_q   <= victim_way;
                        state_q <= S_MISS_AR;
                    end
                end
                S_MISS_AR: begin
                    beat_q <= '0;
                    err_q  <= 1'b0;
                    if (m_arready) begin
                        state_q <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (r_fire) begin
                        beat_q <= beat_q + 1'b1;
                        if (m_rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        // An error fill still installs the line as valid.
                        if (last_beat) begin
                            valid_q[idx_q][way_q] <= 1'b1;
                            plru_q[idx_q]         <= plru_touch(plru_q[idx_q], way_q);
                            state_q               <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (cpu_resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Flush wins over a coinciding request, so ready drops for that cycle.
    assign cpu_req_ready  = (state_q == S_IDLE) && !flush;
    assign cpu_resp_valid = (state_q == S_RESP);
    assign cpu_resp_data  = (state_q == S_RESP) ? da_rdata : '0;
    assign cpu_resp_err   = (state_q == S_RESP) && err_q;

    assign ts_index   = idx_q;
    assign ts_we      = last_beat;
    assign ts_windex  = idx_q;
    assign ts_way     = way_q;
    assign ts_new_tag = tag_q;

    // During a refill the data port follows the beat counter. Otherwise it
    // points at the requested word, so da_rdata is the response word in RESP.
    assign da_we    = r_fire;
    assign da_index = idx_q;
    assign da_way   = way_q;
    assign da_word  = (state_q == S_REFILL) ? beat_q : word_q;
    assign da_wdata = r_fire ? m_rdata : '0;

    assign m_arvalid = (state_q == S_MISS_AR);
    assign m_araddr  = {tag_q, idx_q, 6'b0};
    assign m_arlen   = 8'(BEATS - 1);
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_rready  = (state_q == S_REFILL);

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl -- directed self-checking bench for cache_ctrl.
// The bench models the tag store and the data array as plain memories, and
// it acts as the AXI read slave.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr = '0;
    logic        cpu_resp_valid;
    logic        cpu_resp_ready = 1'b0;
    logic [31:0] cpu_resp_data;
    logic        cpu_resp_err;
    logic        flush = 1'b0;
    logic [6:0]  ts_index;
    logic [18:0] ts_tag0, ts_tag1, ts_tag2, ts_tag3;
    logic        ts_we;
    logic [6:0]  ts_windex;
    logic [1:0]  ts_way;
    logic [18:0] ts_new_tag;
    logic        da_we;
    logic [6:0]  da_index;
    logic [1:0]  da_way;
    logic [3:0]  da_word;
    logic [31:0] da_wdata;
    logic [31:0] da_rdata;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // models of the external memories plus event counters
    logic [18:0] ts_mem [128][4];
    logic [31:0] da_mem [128][4][16];
    int          ts_we_cnt = 0;
    int          da_we_cnt = 0;
    int          ar_cnt = 0;
    logic [6:0]  last_ts_index = '0;
    logic [1:0]  last_ts_way = '0;
    logic [18:0] last_ts_tag = '0;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
        .cpu_resp_data(cpu_resp_data), .cpu_resp_err(cpu_resp_err),
        .flush(flush),
        .ts_index(ts_index), .ts_tag0(ts_tag0), .ts_tag1(ts_tag1), .ts_tag2(ts_tag2), .ts_tag3(ts_tag3),
        .ts_we(ts_we), .ts_windex(ts_windex), .ts_way(ts_way), .ts_new_tag(ts_new_tag),
        .da_we(da_we), .da_index(da_index), .da_way(da_way), .da_word(da_word),
        .da_wdata(da_wdata), .da_rdata(da_rdata),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ts_we) begin
            ts_mem[ts_windex][ts_way] <= ts_new_tag;
            ts_we_cnt     <= ts_we_cnt + 1;
            last_ts_index <= ts_windex;
            last_ts_way   <= ts_way;
            last_ts_tag   <= ts_new_tag;
        end
        if (da_we) begin
            da_mem[da_index][da_way][da_word] <= da_wdata;
            da_we_cnt <= da_we_cnt + 1;
        end
        if (m_arvalid && m_arready) ar_cnt <= ar_cnt + 1;
    end

    assign ts_tag0  = ts_mem[ts_index][0];
    assign ts_tag1  = ts_mem[ts_index][1];
    assign ts_tag2  = ts_mem[ts_index][2];
    assign ts_tag3  = ts_mem[ts_index][3];
    assign da_rdata = da_mem[da_index][da_way][da_word];

    // ---------------- driver tasks ----------------
    // Drive a request. Return at the negedge after the accepting edge.
    // acc is -1 when the request was never accepted.
    task automatic cpu_req(input logic [31:0] addr, output int acc);
        acc = -1;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (cpu_req_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
            end
        end
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (m_arvalid) ok = 1'b1;
        end
    endtask

    task automatic ar_accept();
        m_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_arready = 1'b0;
    endtask

    // Present nbeats R beats, data = base + beat number. err_beat gets SLVERR.
    // With gap set, an idle cycle comes before each odd beat.
    task automatic send_beats(input logic [31:0] base, input int err_beat, input bit gap,
                              input int nbeats, output bit ok);
        ok = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            if (gap && (b % 2 == 1)) begin
                m_rvalid = 1'b0;
                @(negedge clk);
            end
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(b);
            m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            m_rlast  = (b == 15);
            #1;
            if (!m_rready) ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        m_rresp  = 2'b00;
        m_rlast  = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int err_beat,
                           output bit ok, output logic [31:0] araddr_seen);
        int acc;
        bit ok_ar, ok_r;
        cpu_req(addr, acc);
        wait_ar(ok_ar);
        araddr_seen = m_araddr;
        ar_accept();
        send_beats(base, err_beat, 1'b0, 16, ok_r);
        ok = (acc >= 0) && ok_ar && ok_r;
    endtask

    task automatic resp_take();
        cpu_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] ctl;
        @(negedge clk);
        ctl = {cpu_req_ready, cpu_resp_valid, m_arvalid, m_rready, ts_we, da_we, cpu_resp_err};
        checks++;
        if (ctl !== 7'b1000000) begin
            failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b1000000);
        end
        checks++;
        if (cpu_resp_data !== 32'h0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", cpu_resp_data);
        end
    endtask

    task automatic test_cold_miss();
        int acc, ts0, da0;
        bit ok, ok_r;
        ts0 = ts_we_cnt; da0 = da_we_cnt;
        cpu_req(32'h0000_1040, acc);
        wait_ar(ok);
        checks++;
        if (!(ok && acc >= 0)) begin
            failures++; $display("FAIL cold_ar_seen: got acc=%0d ar=%0b expected accepted and ar", acc, ok);
        end
        checks++;
        if (m_araddr !== 32'h0000_1040) begin
            failures++; $display("FAIL cold_araddr: got %h expected 00001040", m_araddr);
        end
        checks++;
        if ({m_arlen, m_arsize, m_arburst} !== {8'd15, 3'b010, 2'b01}) begin
            failures++; $display("FAIL cold_arfields: got len=%0d size=%b burst=%b expected 15 010 01",
                                 m_arlen, m_arsize, m_arburst);
        end
        ar_accept();
        send_beats(32'h0, -1, 1'b0, 16, ok_r);
        // one cycle after the last beat
        checks++;
        if (!(ok_r && cpu_resp_valid === 1'b1)) begin
            failures++; $display("FAIL cold_resp_valid: got valid=%b rready_ok=%b expected 1 1", cpu_resp_valid, ok_r);
        end
        checks++;
        if (cpu_resp_data !== 32'h0 || cpu_resp_err !== 1'b0) begin
            failures++; $display("FAIL cold_resp_data: got %h err=%b expected 0 err=0", cpu_resp_data, cpu_resp_err);
        end
        checks++;
        if ({ts_we_cnt - ts0, last_ts_index, last_ts_way, last_ts_tag} !== {32'd1, 7'h41, 2'd0, 19'h0}) begin
            failures++; $display("FAIL cold_tag_write: got n=%0d set=%h way=%0d tag=%h expected 1 41 0 0",
                                 ts_we_cnt - ts0, last_ts_index, last_ts_way, last_ts_tag);
        end
        checks++;
        if (da_we_cnt - da0 != 16) begin
            failures++; $display("FAIL cold_da_writes: got %0d expected 16", da_we_cnt - da0);
        end
        resp_take();
        checks++;
        if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            failures++; $display("FAIL cold_back_idle: got resp_valid=%b req_ready=%b expected 0 1",
                                 cpu_resp_valid, cpu_req_ready);
        end
    endtask

    task automatic test_hit();
        int acc, ar0;
        ar0 = ar_cnt;
        cpu_req(32'h0000_1044, acc);
        checks++;
        if (acc < 0 || cpu_resp_valid !== 1'b0) begin
            failures++; $display("FAIL hit_t1: got acc=%0d valid=%b expected accepted valid=0", acc, cpu_resp_valid);
        end
        @(negedge clk);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== 32'h1 || cpu_resp_err !== 1'b0) begin
            failures++; $display("FAIL hit_t2: got valid=%b data=%h err=%b expected 1 00000001 0",
                                 cpu_resp_valid, cpu_resp_data, cpu_resp_err);
        end
        resp_take();
        checks++;
        if (ar_cnt != ar0) begin
            failures++; $display("FAIL hit_no_ar: got %0d ar expected 0", ar_cnt - ar0);
        end
    endtask

    task automatic test_replacement();
        bit ok;
        int acc, ar0;
        logic [31:0] araddr_seen;
        // tags 0..3 into set 1, they take ways 0..3 in order
        for (int t = 0; t < 4; t++) begin
            do_miss(32'(t) * 32'h2000 + 32'h40, 32'(t) * 32'h100, -1, ok, araddr_seen);
            checks++;
            if (!ok || last_ts_way !== 2'(t) || cpu_resp_data !== 32'(t) * 32'h100) begin
                failures++; $display("FAIL repl_fill%0d: got ok=%b way=%0d data=%h expected 1 %0d %h",
                                     t, ok, last_ts_way, cpu_resp_data, t, 32'(t) * 32'h100);
            end
            resp_take();
        end
        // touch way 0 (tag 0, word 1)
        ar0 = ar_cnt;
        cpu_req(32'h0000_0044, acc);
        @(negedge clk);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== 32'h1) begin
            failures++; $display("FAIL repl_hit_w0: got valid=%b data=%h expected 1 00000001", cpu_resp_valid, cpu_resp_data);
        end
        resp_take();
        // tag 4: all ways valid, PLRU b0=1 b2=0 -> way 2
        do_miss(32'h0000_8040, 32'h400, -1, ok, araddr_seen);
        checks++;
        if (!ok || araddr_seen !== 32'h0000_8040) begin
            failures++; $display("FAIL repl_ar: got ok=%b araddr=%h expected 1 00008040", ok, araddr_seen);
        end
        checks++;
        if (last_ts_way !== 2'd2 || last_ts_tag !== 19'd4 || cpu_resp_data !== 32'h400) begin
            failures++; $display("FAIL repl_victim: got way=%0d tag=%h data=%h expected 2 4 00000400",
                                 last_ts_way, last_ts_tag, cpu_resp_data);
        end
        resp_take();
        // tag 2 was evicted. PLRU now b0=0 b1=1 -> way 1
        do_miss(32'h0000_4040, 32'h200, -1, ok, araddr_seen);
        checks++;
        if (!ok || ar_cnt - ar0 != 2 || last_ts_way !== 2'd1 || cpu_resp_data !== 32'h200) begin
            failures++; $display("FAIL repl_evicted: got ok=%b ars=%0d way=%0d data=%h expected 1 2 1 00000200",
                                 ok, ar_cnt - ar0, last_ts_way, cpu_resp_data);
        end
        resp_take();
    endtask

    task automatic test_error_fill();
        bit ok;
        int acc, ar0;
        logic [31:0] araddr_seen;
        do_miss(32'h0000_0080, 32'h50, 5, ok, araddr_seen);
        checks++;
        if (!ok || cpu_resp_valid !== 1'b1 || cpu_resp_err !== 1'b1 || cpu_resp_data !== 32'h50) begin
            failures++; $display("FAIL err_fill: got ok=%b valid=%b err=%b data=%h expected 1 1 1 00000050",
                                 ok, cpu_resp_valid, cpu_resp_err, cpu_resp_data);
        end
        resp_take();
        ar0 = ar_cnt;
        cpu_req(32'h0000_0084, acc);
        @(negedge clk);
        checks++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_err !== 1'b0 || cpu_resp_data !== 32'h51 || ar_cnt != ar0) begin
            failures++; $display("FAIL err_rehit: got valid=%b err=%b data=%h ars=%0d expected 1 0 00000051 0",
                                 cpu_resp_valid, cpu_resp_err, cpu_resp_data, ar_cnt - ar0);
        end
        resp_take();
    endtask

    task automatic test_backpressure();
        int acc, da0, bad;
        bit ok, ok_r;
        cpu_req(32'h0000_00C8, acc);
        wait_ar(ok);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_00C0) bad++;
        end
        checks++;
        if (!ok || bad != 0) begin
            failures++; $display("FAIL bp_ar_stable: got ok=%b unstable=%0d expected 1 0", ok, bad);
        end
        ar_accept();
        da0 = da_we_cnt;
        send_beats(32'h700, -1, 1'b1, 16, ok_r);
        checks++;
        if (!ok_r || da_we_cnt - da0 != 16) begin
            failures++; $display("FAIL bp_da_count: got ok=%b writes=%0d expected 1 16", ok_r, da_we_cnt - da0);
        end
        bad = 0;
        for (int w = 0; w < 16; w++) begin
            if (da_mem[3][0][w] !== 32'h700 + 32'(w)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_da_words: got %0d wrong words expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== 32'h702) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_resp_hold: got %0d bad cycles expected 0 (data %h, want 00000702)",
                                 bad, cpu_resp_data);
        end
        resp_take();
    endtask

    task automatic test_flush();
        int acc;
        bit ok, ok_r;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h0000_1044;
        flush = 1'b1;
        #1;
        checks++;
        if (cpu_req_ready !== 1'b0) begin
            failures++; $display("FAIL flush_ready: got %b expected 0", cpu_req_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        checks++;
        if (cpu_req_ready !== 1'b1 || m_arvalid !== 1'b0) begin
            failures++; $display("FAIL flush_stay_idle: got ready=%b arvalid=%b expected 1 0", cpu_req_ready, m_arvalid);
        end
        cpu_req(32'h0000_1044, acc);
        wait_ar(ok);
        checks++;
        if (!ok || m_araddr !== 32'h0000_1040) begin
            failures++; $display("FAIL flush_miss: got ar=%b araddr=%h expected 1 00001040", ok, m_araddr);
        end
        ar_accept();
        send_beats(32'h900, -1, 1'b0, 16, ok_r);
        checks++;
        if (!ok_r || cpu_resp_data !== 32'h901 || last_ts_way !== 2'd0) begin
            failures++; $display("FAIL flush_refill: got ok=%b data=%h way=%0d expected 1 00000901 0",
                                 ok_r, cpu_resp_data, last_ts_way);
        end
        resp_take();
    endtask

    task automatic test_reset_mid_refill();
        int acc, ts0, da0;
        bit ok, ok_r;
        logic [6:0] ctl;
        ts0 = ts_we_cnt;
        cpu_req(32'h0000_0100, acc);
        wait_ar(ok);
        ar_accept();
        da0 = da_we_cnt;
        send_beats(32'hA00, -1, 1'b0, 8, ok_r);
        m_rvalid = 1'b1;
        m_rdata  = 32'hA08;
        #1;
        checks++;
        if (!ok || !ok_r || m_rready !== 1'b1 || da_we !== 1'b1) begin
            failures++; $display("FAIL rst_beat8_live: got ok=%b%b rready=%b da_we=%b expected 11 1 1",
                                 ok, ok_r, m_rready, da_we);
        end
        #1 rst_n = 1'b0;
        #1;
        ctl = {cpu_req_ready, cpu_resp_valid, m_arvalid, m_rready, ts_we, da_we, cpu_resp_err};
        checks++;
        if (ctl !== 7'b1000000 || cpu_resp_data !== 32'h0) begin
            failures++; $display("FAIL rst_mid_outputs: got %b data=%h expected 1000000 0", ctl, cpu_resp_data);
        end
        m_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ts_we_cnt != ts0 || da_we_cnt - da0 != 8) begin
            failures++; $display("FAIL rst_mid_writes: got ts=%0d da=%0d expected 0 8", ts_we_cnt - ts0, da_we_cnt - da0);
        end
        // valid bits are gone: a line that hit before now misses
        cpu_req(32'h0000_0044, acc);
        @(negedge clk);
        checks++;
        if (m_arvalid !== 1'b1 || cpu_resp_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_invalid: got arvalid=%b resp_valid=%b expected 1 0", m_arvalid, cpu_resp_valid);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_replacement();
        test_error_fill();
        test_backpressure();
        test_flush();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
